ex_mem_pipe_n: RTL and testbench

EX_MEM_PIPE_N -- requirements
Module: ex_mem_pipe_n

---
 rtl/ex_mem_pipe_n.sv | 205 ++++++++++++++++++++
 tb/tb_ex_mem_pipe_n.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_n.sv
// EX->MEM pipeline register for LANES parallel issue lanes: a 2-entry (main + skid) buffer with a registered in_ready.
// Define EX_MEM_PIPE_PERF_EN to add the saturating stall_cnt / flush_cnt performance counters.
module ex_mem_pipe_n #(
  parameter int LANES  = 2,
  parameter int DATA_W = 8,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_en,
  input  logic [LANES*DATA_W-1:0] in_result,
  input  logic [LANES*DATA_W-1:0] in_wdata,
  input  logic [LANES*RD_W-1:0]   in_rd,
  input  logic [LANES*4-1:0]      in_ctrl,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_en,
  output logic [LANES*DATA_W-1:0] out_result,
  output logic [LANES*DATA_W-1:0] out_wdata,
  output logic [LANES*RD_W-1:0]   out_rd,
  output logic [LANES*4-1:0]      out_ctrl
`ifdef EX_MEM_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
`endif
);

  localparam int DW = LANES * DATA_W;
  localparam int RW = LANES * RD_W;
  localparam int CW = LANES * 4;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  if (LANES < 1 || LANES > 4 || CNT_W < 1) begin : g_bad_param
    $error("ex_mem_pipe_n: LANES must be 1..4 and CNT_W at least 1");
  end

  logic [1:0]       state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [LANES-1:0] main_en_q, main_en_d, skid_en_q, skid_en_d;
  logic [DW-1:0]    main_res_q, main_res_d, skid_res_q, skid_res_d;
  logic [DW-1:0]    main_wd_q, main_wd_d, skid_wd_q, skid_wd_d;
  logic [RW-1:0]    main_rd_q, main_rd_d, skid_rd_q, skid_rd_d;
  logic [CW-1:0]    main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [CW-1:0]    in_ctrl_gated;
  logic             acc_ok, drn_ok;

  // Disabled lanes must never carry memory or register-write side effects into MEM.
  function automatic logic [CW-1:0] gate_ctrl(input logic [LANES-1:0] en,
                                              input logic [CW-1:0]    ctrl);
    logic [CW-1:0] g;
    g = '0;
    for (int k = 0; k < LANES; k++) begin
      g[k*4 +: 4] = en[k] ? ctrl[k*4 +: 4] : 4'b0000;
    end
    return g;
  endfunction

  assign in_ctrl_gated = gate_ctrl(in_lane_en, in_ctrl);
  assign out_valid     = (state_q != ST_EMPTY);
  assign in_ready      = in_ready_q;

  // Flush swallows any same-cycle accept or drain.
  assign acc_ok = in_valid && in_ready_q && !flush;
  assign drn_ok = out_valid && out_ready && !flush;

  always_comb begin
    state_d     = state_q;
    main_en_d   = main_en_q;
    main_res_d  = main_res_q;
    main_wd_d   = main_wd_q;
    main_rd_d   = main_rd_q;
    main_ctrl_d = main_ctrl_q;
    skid_en_d   = skid_en_q;
    skid_res_d  = skid_res_q;
    skid_wd_d   = skid_wd_q;
    skid_rd_d   = skid_rd_q;
    skid_ctrl_d = skid_ctrl_q;

    case (state_q)
      ST_EMPTY: begin
        if (acc_ok) begin
          main_en_d   = in_lane_en;
          main_res_d  = in_result;
          main_wd_d   = in_wdata;
          main_rd_d   = in_rd;
          main_ctrl_d = in_ctrl_gated;
          state_d     = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc_ok && !drn_ok) begin
          skid_en_d   = in_lane_en;
          skid_res_d  = in_result;
          skid_wd_d   = in_wdata;
          skid_rd_d   = in_rd;
          skid_ctrl_d = in_ctrl_gated;
          state_d     = ST_FULL;
        end else if (acc_ok && drn_ok) begin
          main_en_d   = in_lane_en;
          main_res_d  = in_result;
          main_wd_d   = in_wdata;
          main_rd_d   = in_rd;
          main_ctrl_d = in_ctrl_gated;
        end else if (drn_ok) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (drn_ok) begin
          main_en_d   = skid_en_q;
          main_res_d  = skid_res_q;
          main_wd_d   = skid_wd_q;
          main_rd_d   = skid_rd_q;
          main_ctrl_d = skid_ctrl_q;
          state_d     = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    if (flush) begin
      state_d     = ST_EMPTY;
      main_en_d   = '0;
      main_ctrl_d = '0;
      skid_en_d   = '0;
      skid_ctrl_d = '0;
    end

    in_ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b0;
      main_en_q   <= '0;
      main_res_q  <= '0;
      main_wd_q   <= '0;
      main_rd_q   <= '0;
      main_ctrl_q <= '0;
      skid_en_q   <= '0;
      skid_res_q  <= '0;
      skid_wd_q   <= '0;
      skid_rd_q   <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      main_en_q   <= main_en_d;
      main_res_q  <= main_res_d;
      main_wd_q   <= main_wd_d;
      main_rd_q   <= main_rd_d;
      main_ctrl_q <= main_ctrl_d;
      skid_en_q   <= skid_en_d;
      skid_res_q  <= skid_res_d;
      skid_wd_q   <= skid_wd_d;
      skid_rd_q   <= skid_rd_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign out_lane_en = main_en_q;
  assign out_result  = main_res_q;
  assign out_wdata   = main_wd_q;
  assign out_rd      = main_rd_q;
  assign out_ctrl    = main_ctrl_q;

`ifdef EX_MEM_PIPE_PERF_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic hit);
    return (hit && !(&v)) ? v + CNT_ONE : v;
  endfunction

  assign stall_cnt_d = sat_inc(stall_cnt_q, out_valid && !out_ready);
  assign flush_cnt_d = sat_inc(flush_cnt_q, flush && (state_q != ST_EMPTY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Counters are absent in this build; nothing further to drive.
`endif

endmodule

// File: tb/tb_ex_mem_pipe_n.sv
// Scoreboard bench for ex_mem_pipe_n: a default 2-lane instance and a 4-lane, 16-bit instance.
`timescale 1ns/1ps
module tb_ex_mem_pipe_n;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic        a_in_ready, a_out_valid;
  logic [1:0]  a_in_en = '0, a_out_en;
  logic [15:0] a_in_res = '0, a_in_wd = '0, a_out_res, a_out_wd;
  logic [9:0]  a_in_rd = '0, a_out_rd;
  logic [7:0]  a_in_ctrl = '0, a_out_ctrl;

  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic        b_in_ready, b_out_valid;
  logic [3:0]  b_in_en = '0, b_out_en;
  logic [63:0] b_in_res = '0, b_in_wd = '0, b_out_res, b_out_wd;
  logic [19:0] b_in_rd = '0, b_out_rd;
  logic [15:0] b_in_ctrl = '0, b_out_ctrl;

`ifdef EX_MEM_PIPE_PERF_EN
  logic [15:0] a_stall, a_fcnt, b_stall, b_fcnt;
`endif

  ex_mem_pipe_n u_dut_a (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_lane_en(a_in_en), .in_result(a_in_res), .in_wdata(a_in_wd),
    .in_rd(a_in_rd), .in_ctrl(a_in_ctrl),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_lane_en(a_out_en), .out_result(a_out_res), .out_wdata(a_out_wd),
    .out_rd(a_out_rd), .out_ctrl(a_out_ctrl)
`ifdef EX_MEM_PIPE_PERF_EN
    , .stall_cnt(a_stall), .flush_cnt(a_fcnt)
`endif
  );

  ex_mem_pipe_n #(.LANES(4), .DATA_W(16), .RD_W(5), .CNT_W(16)) u_dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_lane_en(b_in_en), .in_result(b_in_res), .in_wdata(b_in_wd),
    .in_rd(b_in_rd), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_lane_en(b_out_en), .out_result(b_out_res), .out_wdata(b_out_wd),
    .out_rd(b_out_rd), .out_ctrl(b_out_ctrl)
`ifdef EX_MEM_PIPE_PERF_EN
    , .stall_cnt(b_stall), .flush_cnt(b_fcnt)
`endif
  );

  typedef struct {
    logic [63:0] en;
    logic [63:0] res;
    logic [63:0] wd;
    logic [63:0] rd;
    logic [63:0] ctrl;
  } bund_t;

  bund_t qa[$];
  bund_t qb[$];
  int n_checks = 0;
  int n_fail = 0;
  bit armed = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] gate(input int lanes, input logic [3:0] en, input logic [15:0] c);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < lanes; k++) if (en[k]) r[k*4 +: 4] = c[k*4 +: 4];
    return r;
  endfunction

  always @(posedge clk) if (reset) armed = 1'b1;
  always @(negedge reset) armed = 1'b0;

  always @(negedge clk) begin : mon_a
    bund_t e;
    if (reset && armed) begin
      check("a_in_ready", 64'(a_in_ready), 64'(qa.size() < 2));
      check("a_out_valid", 64'(a_out_valid), 64'(qa.size() != 0));
      if (a_flush) qa.delete();
      else begin
        if (a_out_valid && a_out_ready) begin
          if (qa.size() == 0) check("a_unexpected_out", 64'(qa.size()), 64'(1));
          else begin
            e = qa.pop_front();
            check("a_en", 64'(a_out_en), e.en);
            check("a_result", 64'(a_out_res), e.res);
            check("a_wdata", 64'(a_out_wd), e.wd);
            check("a_rd", 64'(a_out_rd), e.rd);
            check("a_ctrl", 64'(a_out_ctrl), e.ctrl);
          end
        end
        if (a_in_valid && a_in_ready)
          qa.push_back('{en: 64'(a_in_en), res: 64'(a_in_res), wd: 64'(a_in_wd), rd: 64'(a_in_rd),
                         ctrl: 64'(gate(2, 4'(a_in_en), 16'(a_in_ctrl)))});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    bund_t e;
    if (reset && armed) begin
      check("b_in_ready", 64'(b_in_ready), 64'(qb.size() < 2));
      check("b_out_valid", 64'(b_out_valid), 64'(qb.size() != 0));
      if (b_flush) qb.delete();
      else begin
        if (b_out_valid && b_out_ready) begin
          if (qb.size() == 0) check("b_unexpected_out", 64'(qb.size()), 64'(1));
          else begin
            e = qb.pop_front();
            check("b_en", 64'(b_out_en), e.en);
            check("b_result", b_out_res, e.res);
            check("b_wdata", b_out_wd, e.wd);
            check("b_rd", 64'(b_out_rd), e.rd);
            check("b_ctrl", 64'(b_out_ctrl), e.ctrl);
          end
        end
        if (b_in_valid && b_in_ready)
          qb.push_back('{en: 64'(b_in_en), res: b_in_res, wd: b_in_wd, rd: 64'(b_in_rd),
                         ctrl: 64'(gate(4, b_in_en, b_in_ctrl))});
      end
    end
  end

  // Call #1 after a rising edge; returns #1 after the edge that accepted the bundle.
  task automatic send_a(input logic [1:0] en, input logic [15:0] res, input logic [15:0] wd,
                        input logic [9:0] rd, input logic [7:0] ctrl);
    bit acc;
    acc = 1'b0;
    a_in_valid = 1'b1; a_in_en = en; a_in_res = res; a_in_wd = wd; a_in_rd = rd; a_in_ctrl = ctrl;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
    end
    check("a_send_accepted", 64'(acc), 64'(1));
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] en, input logic [63:0] res, input logic [63:0] wd,
                        input logic [19:0] rd, input logic [15:0] ctrl);
    bit acc;
    acc = 1'b0;
    b_in_valid = 1'b1; b_in_en = en; b_in_res = res; b_in_wd = wd; b_in_rd = rd; b_in_ctrl = ctrl;
    for (int i = 0; i < 40 && !acc; i++) begin
      @(negedge clk);
      acc = b_in_ready;
      @(posedge clk);
      #1;
    end
    check("b_send_accepted", 64'(acc), 64'(1));
    b_in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cycles(3);
    check("rst_in_ready", 64'(a_in_ready), 64'(0));
    check("rst_out_valid", 64'(a_out_valid), 64'(0));
    check("rst_out_result", 64'(a_out_res), 64'(0));
    check("rst_b_out_ctrl", 64'(b_out_ctrl), 64'(0));
    reset = 1'b1;
    cycles(1);
    check("first_edge_in_ready", 64'(a_in_ready), 64'(1));

    // Single bundle, 1-cycle latency
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    send_a(2'b01, 16'h003C, 16'h0000, 10'd7, 8'h01);
    check("lat_out_valid", 64'(a_out_valid), 64'(1));
    check("lat_result_l0", 64'(a_out_res[7:0]), 64'(8'h3C));
    check("lat_rd_l0", 64'(a_out_rd[4:0]), 64'(5'd7));
    check("lat_ctrl_l0", 64'(a_out_ctrl[3:0]), 64'(4'b0001));
    check("lat_in_ready", 64'(a_in_ready), 64'(1));
    cycles(1);

    // Lane gating
    send_a(2'b10, 16'hA55A, 16'h1234, {5'd3, 5'd9}, 8'hFF);
    check("gate_ctrl", 64'(a_out_ctrl), 64'(8'hF0));
    cycles(2);

    // Backpressure: A and B fill the buffer, C waits
    a_out_ready = 1'b0;
    fork
      begin
        send_a(2'b11, 16'h1111, 16'h0101, {5'd1, 5'd2}, 8'h13);
        send_a(2'b01, 16'h2222, 16'h0202, {5'd3, 5'd4}, 8'h25);
        send_a(2'b11, 16'h3333, 16'h0303, {5'd5, 5'd6}, 8'hC8);
      end
      begin
        cycles(6);
        check("bp_in_ready_full", 64'(a_in_ready), 64'(0));
        check("bp_head_held", 64'(a_out_res), 64'(16'h1111));
        a_out_ready = 1'b1;
      end
    join
    cycles(4);
    check("bp_all_drained", 64'(qa.size()), 64'(0));

    // Flush in FULL with a competing offer
    a_out_ready = 1'b0;
    send_a(2'b11, 16'h4444, 16'h0404, 10'd11, 8'h11);
    send_a(2'b11, 16'h5555, 16'h0505, 10'd12, 8'h22);
    a_in_valid = 1'b1; a_in_en = 2'b11; a_in_res = 16'hDEAD; a_in_ctrl = 8'hFF;
    a_flush = 1'b1;
    cycles(1);
    a_flush = 1'b0;
    a_in_valid = 1'b0;
    check("flush_out_valid", 64'(a_out_valid), 64'(0));
    check("flush_in_ready", 64'(a_in_ready), 64'(1));
    check("flush_ctrl_clear", 64'(a_out_ctrl), 64'(0));
`ifdef EX_MEM_PIPE_PERF_EN
    check("flush_cnt", 64'(a_fcnt), 64'(1));
`endif
    a_out_ready = 1'b1;
    cycles(4);

    // 4-lane instance: latency, packing, gating, backpressure
    send_b(4'b0001, 64'h003C, 64'h0, 20'd7, 16'h0001);
    check("b_lat_out_valid", 64'(b_out_valid), 64'(1));
    check("b_lat_result_l0", 64'(b_out_res[15:0]), 64'(16'h003C));
    check("b_lat_rd_l0", 64'(b_out_rd[4:0]), 64'(5'd7));
    check("b_lat_in_ready", 64'(b_in_ready), 64'(1));
    cycles(1);
    send_b(4'b1111, 64'hDDDD_CCCC_BBBB_AAAA, 64'h4444_3333_2222_1111, {5'd4, 5'd3, 5'd2, 5'd1}, 16'h8421);
    check("b_pack_l3", 64'(b_out_res[63:48]), 64'(16'hDDDD));
    check("b_pack_rd_l2", 64'(b_out_rd[14:10]), 64'(5'd3));
    cycles(1);
    send_b(4'b0101, 64'h1, 64'h2, 20'd3, 16'hFFFF);
    check("b_gate_ctrl", 64'(b_out_ctrl), 64'(16'h0F0F));
    cycles(1);
    b_out_ready = 1'b0;
    fork
      begin
        send_b(4'b1111, 64'hA, 64'h1, 20'd1, 16'h1111);
        send_b(4'b0011, 64'hB, 64'h2, 20'd2, 16'h2222);
        send_b(4'b1100, 64'hC, 64'h3, 20'd3, 16'h3333);
      end
      begin
        cycles(6);
        check("b_bp_in_ready_full", 64'(b_in_ready), 64'(0));
        b_out_ready = 1'b1;
      end
    join
    cycles(4);
    check("b_bp_all_drained", 64'(qb.size()), 64'(0));

    // Asynchronous reset in the middle of a burst
    a_out_ready = 1'b0;
    send_a(2'b11, 16'h6666, 16'h0606, 10'd13, 8'h33);
    send_a(2'b11, 16'h7777, 16'h0707, 10'd14, 8'h44);
    #2;
    reset = 1'b0;
    #1;
    check("arst_out_valid", 64'(a_out_valid), 64'(0));
    check("arst_in_ready", 64'(a_in_ready), 64'(0));
    check("arst_out_en", 64'(a_out_en), 64'(0));
    check("arst_out_result", 64'(a_out_res), 64'(0));
    check("arst_out_wdata", 64'(a_out_wd), 64'(0));
    check("arst_out_rd", 64'(a_out_rd), 64'(0));
    check("arst_out_ctrl", 64'(a_out_ctrl), 64'(0));
    check("arst_b_out_result", b_out_res, 64'(0));
`ifdef EX_MEM_PIPE_PERF_EN
    check("arst_stall_cnt", 64'(a_stall), 64'(0));
    check("arst_flush_cnt", 64'(a_fcnt), 64'(0));
`endif
    qa.delete();
    qb.delete();
    cycles(1);
    reset = 1'b1;
    cycles(1);

    // Five stalled cycles against a valid output
    send_a(2'b01, 16'h0099, 16'h0, 10'd2, 8'h01);
    cycles(5);
`ifdef EX_MEM_PIPE_PERF_EN
    check("stall_cnt", 64'(a_stall), 64'(5));
`endif
    check("stall_head_held", 64'(a_out_res), 64'(16'h0099));
    a_out_ready = 1'b1;
    cycles(3);
    check("end_a_empty", 64'(qa.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
